// File: rtl/fir_seq_pkg.sv
// Shared types and helpers for the FIR sample sequencer: FSM state encoding,
// RAM address width and modular address arithmetic for non power-of-two depths.
package fir_seq_pkg;

   localparam int ADDR_W = 8;
   // Tap counter / fill level width: one bit wider than an address so that a
   // count equal to a full 256-entry RAM is still representable.
   localparam int CNT_W  = ADDR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } seq_state_e;

   // Increment with wrap at depth-1 (explicit compare, depth need not be 2^n).
   function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] addr,
                                                  input int depth);
      if (int'(addr) == depth - 1) begin
         return '0;
      end
      return addr + 1'b1;
   endfunction

   // Decrement with wrap 0 -> depth-1 (explicit compare).
   function automatic logic [ADDR_W-1:0] addr_dec(input logic [ADDR_W-1:0] addr,
                                                  input int depth);
      if (addr == '0) begin
         return ADDR_W'(depth - 1);
      end
      return addr - 1'b1;
   endfunction

endpackage

// File: rtl/fir_sample_sequencer_tap_addr_gen.sv
// Tap read-address generator: walks the circular sample RAM backwards from the
// newest sample, one tap per cycle, and delays {valid, tap} by one stage so it
// lines up with the RAM's registered read data.
module fir_tap_addr_gen
   import fir_seq_pkg::*;
#(
   parameter int TAILLE_MEM = 64,
   parameter int NB_TAPS    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              issue,
   output logic [ADDR_W-1:0] raddr,
   output logic              issue_last,
   output logic              vld_p1,
   output logic [CNT_W-1:0]  tap_p1
);

   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [CNT_W-1:0]  k_q, k_d;
   logic              vld_p1_q, vld_p1_d;
   logic [CNT_W-1:0]  tap_p1_q, tap_p1_d;

   assign issue_last = (k_q == CNT_W'(NB_TAPS - 1));

   // Next-state: load start address, then step tap counter and address per issue.
   always_comb begin
      raddr_d  = raddr_q;
      k_d      = k_q;
      vld_p1_d = issue;
      tap_p1_d = tap_p1_q;
      if (load) begin
         raddr_d = load_addr;
         k_d     = '0;
      end else if (issue) begin
         tap_p1_d = k_q;
         // Address stays on the last tap so it holds outside the read phase.
         if (!issue_last) begin
            k_d     = k_q + 1'b1;
            raddr_d = addr_dec(raddr_q, TAILLE_MEM);
         end
      end
   end

   // Registers: read address, tap counter and the one-stage {valid, tap} pipe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         raddr_q  <= '0;
         k_q      <= '0;
         vld_p1_q <= 1'b0;
         tap_p1_q <= '0;
      end else begin
         raddr_q  <= raddr_d;
         k_q      <= k_d;
         vld_p1_q <= vld_p1_d;
         tap_p1_q <= tap_p1_d;
      end
   end

   assign raddr  = raddr_q;
   assign vld_p1 = vld_p1_q;
   assign tap_p1 = tap_p1_q;

endmodule

// File: rtl/fir_sample_sequencer.sv
// FIR sample sequencer: accepts one sample per pass, writes it into the
// circular sample RAM, then streams the newest NB_TAPS samples (newest first)
// with tap indices to the MAC. Slots not yet written since reset are sent as 0.
module fir_sample_sequencer
   import fir_seq_pkg::*;
#(
   parameter int TAILLE_MOT = 32,
   parameter int TAILLE_MEM = 64,
   parameter int NB_TAPS    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [TAILLE_MOT-1:0] s_data,
   output logic                  ram_wr,
   output logic [ADDR_W-1:0]     ram_waddr,
   output logic [ADDR_W-1:0]     ram_raddr,
   output logic [TAILLE_MOT-1:0] ram_din,
   input  logic [TAILLE_MOT-1:0] ram_dout,
   output logic                  m_valid,
   output logic [TAILLE_MOT-1:0] m_data,
   output logic [ADDR_W-1:0]     m_tap,
   output logic                  m_first,
   output logic                  m_last
);

   seq_state_e            state_q, state_d;
   logic [ADDR_W-1:0]     wptr_q, wptr_d;
   logic [CNT_W-1:0]      fill_q, fill_d;
   logic                  wr_q, wr_d;
   logic [ADDR_W-1:0]     waddr_q, waddr_d;
   logic [TAILLE_MOT-1:0] din_q, din_d;

   logic                  load;
   logic                  issue;
   logic                  issue_last;
   logic                  vld_p1;
   logic [CNT_W-1:0]      tap_p1;
   logic [ADDR_W-1:0]     raddr;

   assign s_ready = (state_q == IDLE) && !reset;

   // Pass FSM: accept -> one write cycle -> NB_TAPS read issues -> drain.
   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      fill_d  = fill_q;
      wr_d    = 1'b0;
      waddr_d = waddr_q;
      din_d   = din_q;
      load    = 1'b0;
      issue   = 1'b0;
      case (state_q)
         IDLE: begin
            if (s_valid && s_ready) begin
               wr_d    = 1'b1;
               waddr_d = wptr_q;
               din_d   = s_data;
               state_d = WRITE;
            end
         end
         WRITE: begin
            // The slot just written becomes the newest tap; reads start there.
            wptr_d  = addr_inc(wptr_q, TAILLE_MEM);
            fill_d  = (fill_q == CNT_W'(NB_TAPS)) ? fill_q : fill_q + 1'b1;
            load    = 1'b1;
            state_d = READ;
         end
         READ: begin
            issue = 1'b1;
            if (issue_last) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and RAM-port registers; everything clears on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         wptr_q  <= '0;
         fill_q  <= '0;
         wr_q    <= 1'b0;
         waddr_q <= '0;
         din_q   <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         fill_q  <= fill_d;
         wr_q    <= wr_d;
         waddr_q <= waddr_d;
         din_q   <= din_d;
      end
   end

   fir_tap_addr_gen #(
      .TAILLE_MEM (TAILLE_MEM),
      .NB_TAPS    (NB_TAPS)
   ) u_tap_addr_gen (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_addr  (wptr_q),
      .issue      (issue),
      .raddr      (raddr),
      .issue_last (issue_last),
      .vld_p1     (vld_p1),
      .tap_p1     (tap_p1)
   );

   assign ram_wr    = wr_q;
   assign ram_waddr = waddr_q;
   assign ram_din   = din_q;
   assign ram_raddr = raddr;

   // Taps beyond the fill level point at never-written RAM and are forced to 0.
   assign m_valid = vld_p1;
   assign m_data  = (vld_p1 && (tap_p1 < fill_q)) ? ram_dout : '0;
   assign m_tap   = vld_p1 ? tap_p1[ADDR_W-1:0] : '0;
   assign m_first = vld_p1 && (tap_p1 == '0);
   assign m_last  = vld_p1 && (tap_p1 == CNT_W'(NB_TAPS - 1));

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Bench for fir_sample_sequencer: two instances (4 taps / 8 words and 8 taps /
// 8 words) each on a registered-read RAM model, checked every cycle against a
// schedule-based reference model, plus literal expectations for key passes.
module tb_fir_sample_sequencer;

   localparam int MEM = 8;
   localparam int CYC = 8192;

   typedef struct {
      bit          v;
      int          tap;
      logic [31:0] data;
      bit          wr;
      int          waddr;
      logic [31:0] din;
      bit          rchk;
      int          raddr;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic [1:0]       s_valid, s_ready, ram_wr, m_valid, m_first, m_last;
   logic [1:0][31:0] s_data, ram_din, ram_dout, m_data;
   logic [1:0][7:0]  ram_waddr, ram_raddr, m_tap;

   int checks = 0;
   int errors = 0;

   exp_t        ex [2][CYC];
   logic [31:0] hist [2][256];
   int          nxt [2];
   int          wcnt [2];
   int          prev_raddr [2];
   int          wr_pulses [2];
   logic [31:0] o_data [2][$];
   int          o_tap [2][$];
   int          o_first [2][$];
   int          o_last [2][$];
   int          o_raddr [2][$];
   int          o_vcyc [2][$];
   int          o_waddr [2][$];
   logic [31:0] o_din [2][$];
   int          o_hs [2][$];
   logic [31:0] mem [2][MEM];

   always #5 clk = ~clk;

   fir_sample_sequencer #(.TAILLE_MOT(32), .TAILLE_MEM(MEM), .NB_TAPS(4)) dut_a (
      .clk(clk), .reset(reset), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
      .s_data(s_data[0]), .ram_wr(ram_wr[0]), .ram_waddr(ram_waddr[0]),
      .ram_raddr(ram_raddr[0]), .ram_din(ram_din[0]), .ram_dout(ram_dout[0]),
      .m_valid(m_valid[0]), .m_data(m_data[0]), .m_tap(m_tap[0]),
      .m_first(m_first[0]), .m_last(m_last[0]));

   fir_sample_sequencer #(.TAILLE_MOT(32), .TAILLE_MEM(MEM), .NB_TAPS(8)) dut_b (
      .clk(clk), .reset(reset), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
      .s_data(s_data[1]), .ram_wr(ram_wr[1]), .ram_waddr(ram_waddr[1]),
      .ram_raddr(ram_raddr[1]), .ram_din(ram_din[1]), .ram_dout(ram_dout[1]),
      .m_valid(m_valid[1]), .m_data(m_data[1]), .m_tap(m_tap[1]),
      .m_first(m_first[1]), .m_last(m_last[1]));

   // Sample RAMs: registered read, read ignored while wr is high; filled with
   // junk so that any forwarding of unwritten slots is visible.
   initial begin
      for (int i = 0; i < 2; i++)
         for (int a = 0; a < MEM; a++)
            mem[i][a] <= 32'hDEAD_0000 | (i << 8) | a;
      ram_dout <= '0;
      forever begin
         @(posedge clk);
         for (int i = 0; i < 2; i++) begin
            if (ram_wr[i])
               mem[i][ram_waddr[i][2:0]] <= ram_din[i];
            else if (ram_raddr[i] < 8'(MEM))
               ram_dout[i] <= mem[i][ram_raddr[i][2:0]];
         end
      end
   end

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Reference model + per-cycle compare. A handshake seen in cycle c
   // schedules: write at c+1, read address of tap j at c+2+j, tap j out at
   // c+3+j, next acceptance at c+NB+3.
   initial begin : compare
      int   c;
      int   nb;
      int   n;
      bit   rdy;
      exp_t e;
      c = 0;
      for (int i = 0; i < 2; i++) begin
         nxt[i] = 0; wcnt[i] = 0; prev_raddr[i] = 0; wr_pulses[i] = 0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            nb = (i == 0) ? 4 : 8;
            if (reset) begin
               cmp($sformatf("reset_ctl[%0d]", i),
                   32'({s_ready[i], ram_wr[i], m_valid[i], m_first[i], m_last[i],
                        ram_waddr[i], ram_raddr[i], m_tap[i]}), 32'h0);
               cmp($sformatf("reset_data[%0d]", i), m_data[i] | ram_din[i], 32'h0);
               wcnt[i] = 0;
               nxt[i]  = c + 1;
               for (int k = c; k < c + 16 && k < CYC; k++) ex[i][k] = '{default: 0};
            end else if (c < CYC - 16) begin
               e   = ex[i][c];
               rdy = (c >= nxt[i]);
               cmp($sformatf("s_ready[%0d]", i), 32'(s_ready[i]), 32'(rdy));
               cmp($sformatf("ram_wr[%0d]", i), 32'(ram_wr[i]), 32'(e.wr));
               if (e.wr) begin
                  cmp($sformatf("ram_waddr[%0d]", i), 32'(ram_waddr[i]), e.waddr);
                  cmp($sformatf("ram_din[%0d]", i), ram_din[i], e.din);
               end
               if (e.rchk)
                  cmp($sformatf("ram_raddr[%0d]", i), 32'(ram_raddr[i]), e.raddr);
               cmp($sformatf("m_valid[%0d]", i), 32'(m_valid[i]), 32'(e.v));
               if (e.v) begin
                  cmp($sformatf("m_data[%0d]", i), m_data[i], e.data);
                  cmp($sformatf("m_tap[%0d]", i), 32'(m_tap[i]), e.tap);
                  cmp($sformatf("m_first[%0d]", i), 32'(m_first[i]), 32'(e.tap == 0));
                  cmp($sformatf("m_last[%0d]", i), 32'(m_last[i]), 32'(e.tap == nb - 1));
               end
               if (m_valid[i]) begin
                  o_data[i].push_back(m_data[i]);
                  o_tap[i].push_back(int'(m_tap[i]));
                  o_first[i].push_back(int'(m_first[i]));
                  o_last[i].push_back(int'(m_last[i]));
                  o_raddr[i].push_back(prev_raddr[i]);
                  o_vcyc[i].push_back(c);
               end
               if (ram_wr[i]) begin
                  wr_pulses[i]++;
                  o_waddr[i].push_back(int'(ram_waddr[i]));
                  o_din[i].push_back(ram_din[i]);
               end
               if (s_valid[i] && rdy && wcnt[i] < 255) begin
                  n = wcnt[i] + 1;
                  wcnt[i] = n;
                  hist[i][n-1] = s_data[i];
                  o_hs[i].push_back(c);
                  ex[i][c+1].wr    = 1'b1;
                  ex[i][c+1].waddr = (n - 1) % MEM;
                  ex[i][c+1].din   = s_data[i];
                  for (int j = 0; j < nb; j++) begin
                     ex[i][c+2+j].rchk  = 1'b1;
                     ex[i][c+2+j].raddr = (((n - 1 - j) % MEM) + MEM) % MEM;
                     ex[i][c+3+j].v     = 1'b1;
                     ex[i][c+3+j].tap   = j;
                     ex[i][c+3+j].data  = (j < n) ? hist[i][n-1-j] : 32'h0;
                  end
                  nxt[i] = c + nb + 3;
               end
            end
            prev_raddr[i] = int'(ram_raddr[i]);
         end
         c++;
      end
   end

   task automatic send(input int i, input logic [31:0] d, input bit hold);
      bit got;
      got = 1'b0;
      s_valid[i] = 1'b1;
      s_data[i]  = d;
      for (int k = 0; k < 60 && !got; k++) begin
         @(negedge clk);
         if (s_ready[i]) got = 1'b1;
      end
      if (!got) cmp($sformatf("send_timeout[%0d]", i), 32'(got), 32'h1);
      @(posedge clk); #1;
      if (!hold) s_valid[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i);
      bit got;
      got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
         @(negedge clk);
         if (s_ready[i]) got = 1'b1;
      end
      if (!got) cmp($sformatf("idle_timeout[%0d]", i), 32'(got), 32'h1);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Compare the last cnt emitted taps of instance i (sel: 0 data, 1 raddr,
   // 2 tap, 3 first, 4 last) against literal expectations.
   task automatic tail_chk(input string nm, input int i, input int sel, input int cnt,
                           input logic [31:0] req [8]);
      int L;
      int idx;
      logic [31:0] v;
      L = o_data[i].size();
      if (L < cnt) begin
         cmp({nm, "_len"}, 32'(L), 32'(cnt));
         return;
      end
      for (int j = 0; j < cnt; j++) begin
         idx = L - cnt + j;
         case (sel)
            0: v = o_data[i][idx];
            1: v = 32'(o_raddr[i][idx]);
            2: v = 32'(o_tap[i][idx]);
            3: v = 32'(o_first[i][idx]);
            default: v = 32'(o_last[i][idx]);
         endcase
         cmp($sformatf("%s[%0d]", nm, j), v, req[j]);
      end
   endtask

   initial begin : stim
      logic [31:0] sv [9];
      int w0;
      int L;
      s_valid = '0;
      s_data  = '0;
      reset   = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // 1: single sample after reset
      send(0, 32'h11, 1'b0);
      wait_idle(0);
      cmp("t1_waddr", 32'(o_waddr[0][$]), 32'h0);
      cmp("t1_din", o_din[0][$], 32'h11);
      tail_chk("t1_data", 0, 0, 4, '{32'h11, 0, 0, 0, 0, 0, 0, 0});
      tail_chk("t1_tap", 0, 2, 4, '{0, 1, 2, 3, 0, 0, 0, 0});
      tail_chk("t1_first", 0, 3, 4, '{1, 0, 0, 0, 0, 0, 0, 0});
      tail_chk("t1_last", 0, 4, 4, '{0, 0, 0, 1, 0, 0, 0, 0});
      L = o_vcyc[0].size();
      if (L >= 4) cmp("t1_latency", 32'(o_vcyc[0][L-4] - o_hs[0][$]), 32'd3);

      // 2: five samples, fifth pass
      do_reset();
      for (int k = 1; k <= 5; k++) send(0, 32'h11 * k, 1'b0);
      wait_idle(0);
      tail_chk("t2_data", 0, 0, 4, '{32'h55, 32'h44, 32'h33, 32'h22, 0, 0, 0, 0});
      tail_chk("t2_raddr", 0, 1, 4, '{4, 3, 2, 1, 0, 0, 0, 0});

      // 3: nine random samples, write pointer wraps
      do_reset();
      for (int k = 0; k < 9; k++) begin
         sv[k] = $urandom;
         send(0, sv[k], 1'b0);
      end
      wait_idle(0);
      cmp("t3_waddr", 32'(o_waddr[0][$]), 32'h0);
      tail_chk("t3_raddr", 0, 1, 4, '{0, 7, 6, 5, 0, 0, 0, 0});
      tail_chk("t3_data", 0, 0, 4, '{sv[8], sv[7], sv[6], sv[5], 0, 0, 0, 0});

      // 4: s_valid held high across passes
      do_reset();
      w0 = wr_pulses[0];
      for (int k = 0; k < 4; k++) send(0, 32'hA0 + k, 1'b1);
      s_valid[0] = 1'b0;
      wait_idle(0);
      cmp("t4_wr_pulses", 32'(wr_pulses[0] - w0), 32'd4);
      L = o_hs[0].size();
      for (int j = 1; j < 4; j++)
         cmp($sformatf("t4_period[%0d]", j), 32'(o_hs[0][L-4+j] - o_hs[0][L-5+j]), 32'd7);

      // 5: reset during the read phase of the third pass
      do_reset();
      for (int k = 1; k <= 3; k++) send(0, 32'h30 + k, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      send(0, 32'h77, 1'b0);
      wait_idle(0);
      cmp("t5_waddr", 32'(o_waddr[0][$]), 32'h0);
      tail_chk("t5_data", 0, 0, 4, '{32'h77, 0, 0, 0, 0, 0, 0, 0});

      // 6: NB_TAPS == TAILLE_MEM instance, ten samples
      do_reset();
      for (int k = 1; k <= 10; k++) send(1, 32'(k), 1'b0);
      wait_idle(1);
      tail_chk("t6_raddr", 1, 1, 8, '{1, 0, 7, 6, 5, 4, 3, 2});
      tail_chk("t6_data", 1, 0, 8, '{10, 9, 8, 7, 6, 5, 4, 3});

      // 7: random traffic on both instances, model-checked every cycle
      do_reset();
      for (int it = 0; it < 60; it++) begin
         send(int'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 1)));
         for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
            @(posedge clk); #1;
         end
      end
      s_valid = '0;
      wait_idle(0);
      wait_idle(1);
      repeat (4) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required finish before 2000000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fir_sample_sequencer.md
Name: fir_sample_sequencer

Overview:
Controller for the FIR sample RAM, on the opposite side of that RAM's write/read port. It accepts one new sample per filter pass over a valid/ready handshake and writes it into the circular sample RAM. It then reads the last NB_TAPS samples back, newest first, and streams them with tap indices to the MAC stage. It handles the RAM's one-cycle read latency and its rule that reads are ignored while wr is high.

Parameters:
TAILLE_MOT, 32, sample word width
TAILLE_MEM, 64, RAM depth in words; need not be a power of two
NB_TAPS, 16, taps per pass; 1 <= NB_TAPS <= TAILLE_MEM

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
s_valid  in  1  new sample offered
s_ready  out  1  sequencer can accept a sample
s_data  in  TAILLE_MOT  sample value
ram_wr  out  1  RAM write strobe; RAM reads only when low
ram_waddr  out  8  RAM write address
ram_raddr  out  8  RAM read address
ram_din  out  TAILLE_MOT  RAM write data
ram_dout  in  TAILLE_MOT  RAM registered read data (valid one cycle after raddr is sampled with wr=0)
m_valid  out  1  tap sample valid to MAC
m_data  out  TAILLE_MOT  tap sample
m_tap  out  8  tap index, 0 = newest
m_first  out  1  with m_valid, tap 0
m_last  out  1  with m_valid, tap NB_TAPS-1

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- On reset: state IDLE; wptr=0; fill=0. s_ready=1 once out of reset. All other outputs are 0.
- Reset mid-pass aborts immediately. The in-flight sample is lost.
- All RAM control outputs are registered. m_data is ram_dout gated combinationally, or zero-forced.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - s_ready=1.
  - On s_valid & s_ready (cycle 0): next cycle ram_wr=1, ram_waddr=wptr, ram_din=s_data; go to WRITE.
- WRITE (cycle 1):
  - ram_wr=1 for exactly this cycle. s_ready=0.
  - At the end of the cycle: newest<=wptr; wptr<=(wptr==TAILLE_MEM-1)?0:wptr+1; fill<=min(fill+1,NB_TAPS); ram_wr<=0; ram_raddr<=wptr; issue counter k<=0; go to READ.
- READ (cycles 2 .. NB_TAPS+1):
  - Each cycle issues tap k at ram_raddr = (newest-k) mod TAILLE_MEM.
  - Decrement wraps 0 -> TAILLE_MEM-1 by explicit compare.
  - Pipeline register captures {valid, k}.
  - After issuing k=NB_TAPS-1, go to DRAIN.
- DRAIN (cycle NB_TAPS+2):
  - Last tap emerges.
  - Next cycle go to IDLE.
- Output timing:
  - m_valid=1 in cycles 3 .. NB_TAPS+2. m_tap=k. m_first when k=0; m_last when k=NB_TAPS-1. Both are set together when NB_TAPS=1.
  - m_data=ram_dout when k<fill, otherwise 0. Unwritten RAM content is never forwarded.
- Latency: input handshake to first m_valid is 3 cycles. Pass period is NB_TAPS+3 cycles.
- s_ready=0 in WRITE, READ and DRAIN. A held s_valid is accepted on the first IDLE cycle.
- ram_wr is never high in READ or DRAIN. ram_raddr holds its last value outside READ.
- Wrap-around: wptr and read addresses stay in [0, TAILLE_MEM-1] for any TAILLE_MEM. Addresses are zero-extended to 8 bits.
- NB_TAPS=TAILLE_MEM is legal: the oldest tap reads the slot written TAILLE_MEM samples earlier.

Decomposition:
- Package fir_seq_pkg contains:
  - state enum {IDLE, WRITE, READ, DRAIN}
  - ADDR_W=8 constant
  - functions addr_inc/addr_dec(addr, depth) for modular arithmetic
- One sub-module is natural: fir_tap_addr_gen. It holds the tap counter k, the read-address decrement and the 1-stage {valid, k} latency pipeline.
- The FSM, wptr and fill stay in the top level.

Test Plan (NB_TAPS=4, TAILLE_MEM=8, bench RAM model matching registered read/blocked-on-write):
1. After reset, send 0x11 -> cycle 1 ram_wr=1, waddr=0, din=0x11; cycles 3-6 m_data=0x11,0,0,0, m_tap=0..3, m_first at cycle 3, m_last at cycle 6.
2. Send 0x11,0x22,0x33,0x44,0x55 -> fifth pass outputs 0x55,0x44,0x33,0x22 with raddr 4,3,2,1.
3. Send 9 samples -> 9th written at waddr=0; its pass reads raddr 0,7,6,5.
4. Hold s_valid high continuously -> s_ready is low during passes, accepts exactly every 7 cycles, one ram_wr pulse per sample, no ram_wr during READ.
5. Assert reset during READ of the third pass -> outputs 0 immediately; next sample written at waddr=0 with taps 1-3 zero-forced.
6. NB_TAPS=8, TAILLE_MEM=8, 10 samples -> last pass reads raddr 1,0,7,6,5,4,3,2 and returns samples 10 down to 3.
